// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   PC_W / INSTR_W : address and instruction widths
//   NOP_INSTR      : value shown on the instruction bus when nothing is valid
//   PC_STEP        : byte increment between sequential fetches
//   fq_entry_t     : one fetch-queue entry {instr, pc}
package if_fetch_stage_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0]    PC_STEP   = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;
endpackage

// File: rtl/if_fetch_stage_fifo.sv
// fetch_fifo: small circular queue holding fetched {instr, pc} entries.
//   clk_i, rst_i   : clock, synchronous active-high reset (empties queue)
//   flush_i        : synchronous flush, wins over push/pop
//   push_i/push_data_i : write tail
//   pop_i          : advance head (caller guarantees non-empty)
//   head_o         : entry at head (meaningful only when count_o != 0)
//   count_o        : number of stored entries
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer increment that wraps at DEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      // Push and pop together when full is safe: the slot being written is
      // the one whose contents leave this cycle.
      if (push_i) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = nxt(wr_q);
      end
      if (pop_i) rd_d = nxt(rd_q);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and fetch front end ahead of ID.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   redirect_i/redirect_pc_i : taken branch/jump/jr; flushes and refetches
//   imem_req_o/imem_addr_o : fetch request to 1-cycle synchronous imem
//   imem_instr_i           : instruction, valid the cycle after the request
//   ifid_valid_o/ready_i   : handshake to ID
//   ifid_instr_o/pc_o/pc4_o: head instruction, its PC, and PC+4
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              FQ_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic               ifid_valid_o,
  input  logic               ifid_ready_i,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [PC_W-1:0]    ifid_pc4_o
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [PC_W-1:0] pc_q, pc_d, tag_q, tag_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   fq_count;
  logic [OW-1:0]   occ;
  logic            fq_valid, pop, req, push;
  fq_entry_t       push_entry, head_entry;

  assign fq_valid = (fq_count != '0);
  assign pop      = fq_valid & ifid_ready_i;

  // Credits: stored entries plus the response still on its way, less the
  // entry leaving now, must leave room for the response to this request.
  assign occ = OW'(fq_count) + OW'(inflight_q) - OW'(pop);
  assign req = !rst_i && !redirect_i && (occ < OW'(FQ_DEPTH));

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
    end else if (req) begin
      pc_d       = pc_q + PC_STEP;
      inflight_d = 1'b1;
      tag_d      = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // A response landing in a redirect cycle belongs to the squashed path.
  assign push             = inflight_q & !redirect_i;
  assign push_entry.instr = imem_instr_i;
  assign push_entry.pc    = tag_q;

  fetch_fifo #(.DEPTH(FQ_DEPTH), .WIDTH($bits(fq_entry_t))) u_fq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .count_o     (fq_count)
  );

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;
  assign ifid_valid_o = fq_valid;
  // Data buses read as zero when nothing is valid (incl. right after reset).
  assign ifid_instr_o = fq_valid ? head_entry.instr : NOP_INSTR;
  assign ifid_pc_o    = fq_valid ? head_entry.pc : '0;
  assign ifid_pc4_o   = fq_valid ? head_entry.pc + PC_STEP : '0;
endmodule
